// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic operand skew path.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH} skew_state_t;

  // Zero-based tap of column c, i.e. its delay in advances minus one.
  function automatic int unsigned skew_tap(input int unsigned base, input int unsigned cols,
                                           input int unsigned c, input logic rev);
    return rev ? (base + cols - 2 - c) : (base + c - 1);
  endfunction

endpackage

// File: rtl/skew_tap_line.sv
// Shift line of tagged elements with a runtime output tap; one instance per array column.
module skew_tap_line #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 8,
  parameter int unsigned TapW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic [Width-1:0] din,
  input  logic [TapW-1:0]  tap,
  output logic [Width-1:0] dout
);

  logic [Depth-1:0][Width-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (shift) begin
      line_d[0] = din;
      for (int i = 1; i < Depth; i++) line_d[i] = line_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) line_q <= '0;
    else        line_q <= line_d;
  end

  assign dout = line_q[tap];

endmodule

// File: rtl/mem_skew_loader.sv
// Accepts one B-operand tile row by row and presents each column with its own skew delay,
// zero padded and tagged, for the systolic array column inputs.
module mem_skew_loader
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_AB  = 8,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned BASE_DLY = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                start,
  input  logic                                rev,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [COLS-1:0][BITS_AB-1:0] Bin,
  output logic signed [COLS-1:0][BITS_AB-1:0] Bout,
  output logic [COLS-1:0]                     out_valid,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned MAXD   = BASE_DLY + COLS - 1;
  localparam int unsigned RowW   = $clog2(ROWS + 1);
  localparam int unsigned FlW    = $clog2(MAXD + 1);
  localparam int unsigned TapW   = (MAXD > 1) ? $clog2(MAXD) : 1;
  localparam int unsigned FlLast = (MAXD > 1) ? MAXD - 1 : 1;

  typedef struct packed {
    logic                      vld;
    logic signed [BITS_AB-1:0] data;
  } elem_t;

  skew_state_t     state_q, state_d;
  logic [RowW-1:0] row_cnt_q, row_cnt_d;
  logic [FlW-1:0]  fl_cnt_q, fl_cnt_d;
  logic            rev_q, rev_d;
  logic            done_q, done_d;
  logic            accept, adv;

  // A stalled FEED cycle freezes every line so no bubble enters the skew.
  assign accept = (state_q == FEED) && en && in_valid;
  assign adv    = (state_q == FEED) ? accept : en;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    rev_d     = rev_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && start) begin
          state_d   = FEED;
          rev_d     = rev;
          row_cnt_d = '0;
        end
      end
      FEED: begin
        if (accept) begin
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == RowW'(ROWS - 1)) begin
            state_d  = FLUSH;
            fl_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        if (en) begin
          fl_cnt_d = fl_cnt_q + 1'b1;
          if (fl_cnt_d == FlW'(FlLast)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      fl_cnt_q  <= '0;
      rev_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      rev_q     <= rev_d;
      done_q    <= done_d;
    end
  end

  assign in_ready = (state_q == FEED);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    elem_t           din, dout;
    logic [TapW-1:0] tap;

    assign din.vld  = accept;
    assign din.data = accept ? Bin[c] : '0;
    assign tap      = TapW'(skew_tap(BASE_DLY, COLS, c, rev_q));

    skew_tap_line #(
      .Width ($bits(elem_t)),
      .Depth (MAXD),
      .TapW  (TapW)
    ) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .shift (adv),
      .din   (din),
      .tap   (tap),
      .dout  (dout)
    );

    assign Bout[c]      = dout.data;
    assign out_valid[c] = dout.vld;
  end

endmodule

// File: tb/tb_mem_skew_loader.sv
// Directed bench for mem_skew_loader with a 4x4 tile and base delay 4.
module tb_mem_skew_loader;

  localparam int unsigned BW   = 8;
  localparam int unsigned NR   = 4;
  localparam int unsigned NC   = 4;
  localparam int unsigned BD   = 4;
  localparam int unsigned MAXD = BD + NC - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, start = 1'b0, rev = 1'b0, in_valid = 1'b0;
  logic in_ready, busy, done;
  logic [NC-1:0][BW-1:0] Bin = '0;
  logic [NC-1:0][BW-1:0] Bout;
  logic [NC-1:0]         out_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_adv[NR];
  int adv_n;

  mem_skew_loader #(
    .BITS_AB  (BW),
    .ROWS     (NR),
    .COLS     (NC),
    .BASE_DLY (BD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .rev       (rev),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Bin       (Bin),
    .Bout      (Bout),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dly(input int c, input logic rv);
    return rv ? int'(BD + NC - 1) - c : int'(BD) + c;
  endfunction

  function automatic logic [BW-1:0] elem(input int r, input int c, input int off);
    logic [BW-1:0] v;
    v = BW'(r * 10 + c + off);
    return v;
  endfunction

  function automatic logic [NC-1:0][BW-1:0] row_vec(input int r, input int off);
    logic [NC-1:0][BW-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = elem(r, c, off);
    return v;
  endfunction

  // One tile from its start edge (t=0) through the expected done edge; outputs are checked
  // every edge against the advance-indexed arrival of each accepted element.
  task automatic run_tile(input string nm, input logic rv, input int off,
                          input int stall_at, input int stall_len,
                          input int enoff_at, input int enoff_len,
                          input logic poke, input int exp_done_t);
    int                    rows;
    int                    done_t;
    logic                  feeding, fin, exp_done;
    logic [NC-1:0][BW-1:0] eb;
    logic [NC-1:0]         ev;
    rows   = 0;
    done_t = -1;
    fin    = 1'b0;
    adv_n  = 0;
    for (int t = 0; t < 40 && !fin; t++) begin
      start    = (t == 0) || (poke && t == 2);
      rev      = (t == 0) ? rv : ~rv;
      en       = !(t >= enoff_at && t < enoff_at + enoff_len);
      feeding  = (t > 0) && (rows < NR);
      in_valid = (rows < NR) && !(t >= stall_at && t < stall_at + stall_len);
      Bin      = row_vec((rows < NR) ? rows : 0, off);
      step();
      exp_done = 1'b0;
      if (t > 0) begin
        if (feeding) begin
          if (en && in_valid) begin
            adv_n++;
            acc_adv[rows] = adv_n;
            rows++;
          end
        end else if (en) begin
          adv_n++;
          exp_done = (adv_n == acc_adv[NR-1] + int'(MAXD) - 1);
        end
      end
      if (exp_done) fin = 1'b1;
      eb = '0;
      ev = '0;
      for (int c = 0; c < NC; c++) begin
        for (int r = 0; r < rows; r++) begin
          if (adv_n == acc_adv[r] + dly(c, rv) - 1) begin
            ev[c] = 1'b1;
            eb[c] = elem(r, c, off);
          end
        end
      end
      check($sformatf("%s t%0d Bout", nm, t), 32'(Bout), 32'(eb));
      check($sformatf("%s t%0d out_valid", nm, t), 32'(out_valid), 32'(ev));
      check($sformatf("%s t%0d done", nm, t), 32'(done), 32'(exp_done));
      check($sformatf("%s t%0d busy", nm, t), 32'(busy), 32'(!fin));
      check($sformatf("%s t%0d in_ready", nm, t), 32'(in_ready), 32'(rows < NR));
      if (done === 1'b1 && done_t < 0) done_t = t;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    en       = 1'b1;
    check($sformatf("%s done edge", nm), 32'(done_t), 32'(exp_done_t));
  endtask

  initial begin
    // Reset state
    #12;
    check("reset Bout", 32'(Bout), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    #1 rst_n = 1'b1;
    en = 1'b1;
    step();
    step();
    check("idle busy", 32'(busy), 32'h0);
    check("idle in_ready", 32'(in_ready), 32'h0);

    // Basic skew, then reverse mode back-to-back
    run_tile("basic", 1'b0, 0, 1000, 0, 1000, 0, 1'b0, 10);
    run_tile("reverse", 1'b1, 0, 1000, 0, 1000, 0, 1'b0, 10);

    // Input stall between rows 1 and 2
    step();
    run_tile("stall", 1'b0, 0, 3, 3, 1000, 0, 1'b0, 13);

    // en held low for 5 cycles mid-flush
    step();
    run_tile("en_gate", 1'b0, 0, 1000, 0, 7, 5, 1'b0, 15);

    // start pulsed during FEED, then a second tile straight after done with negative data
    step();
    run_tile("start_ign", 1'b0, 0, 1000, 0, 1000, 0, 1'b1, 10);
    run_tile("b2b", 1'b1, -100, 1000, 0, 1000, 0, 1'b0, 10);

    // Reset during FEED after two rows
    step();
    start = 1'b1;
    rev   = 1'b0;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    Bin      = row_vec(0, 0);
    step();
    Bin = row_vec(1, 0);
    step();
    in_valid = 1'b0;
    check("pre-rst in_ready", 32'(in_ready), 32'h1);
    check("pre-rst busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst Bout", 32'(Bout), 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst hold %0d done", i), 32'(done), 32'h0);
    end
    #2 rst_n = 1'b1;
    step();
    check("post-rst done", 32'(done), 32'h0);
    check("post-rst busy", 32'(busy), 32'h0);
    run_tile("after_rst", 1'b0, 0, 1000, 0, 1000, 0, 1'b0, 10);

    step();
    check("final done", 32'(done), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
